// File: rtl/dili_intt_scale.sv
// Final INTT scaling stage: multiplies each coefficient by F, Montgomery-reduces it
// and emits canonical values in [0, Q) through a three-stage valid/ready pipeline.
module dili_intt_scale #(
    parameter int          WIDTH = 32,
    parameter int unsigned QINV  = 32'd58728449,
    parameter int          Q     = 8380417,
    parameter int          N     = 256,
    parameter int          F     = 41978,
    parameter int          IW    = $clog2(N)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [IW-1:0]    out_idx_o,
    output logic             out_last_o,
    output logic             frame_err_o
);

    localparam int DW = 2 * WIDTH;

    localparam logic [DW-1:0]    F_EXT    = DW'(F);
    localparam logic [DW-1:0]    Q_EXT    = DW'(Q);
    localparam logic [WIDTH-1:0] QINV_W   = WIDTH'(QINV);
    localparam logic [WIDTH-1:0] Q_W      = WIDTH'(Q);
    localparam logic [IW-1:0]    LAST_IDX = IW'(N - 1);

    logic             en;
    logic             accept;
    logic             xfer;

    logic             s1_valid_reg;
    logic [DW-1:0]    s1_prod_reg;
    logic [DW-1:0]    s1_prod_next;

    logic             s2_valid_reg;
    logic [DW-1:0]    s2_prod_reg;
    logic [WIDTH-1:0] s2_t_reg;
    logic [WIDTH-1:0] s2_t_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [WIDTH-1:0] out_data_next;

    logic [IW-1:0]    in_cnt_reg;
    logic [IW-1:0]    in_cnt_next;
    logic [IW-1:0]    out_cnt_reg;
    logic [IW-1:0]    out_cnt_next;
    logic             frame_err_reg;
    logic             frame_err_next;

    logic [DW-1:0]    in_ext;
    logic [DW-1:0]    t_ext;
    logic [DW-1:0]    tq;
    logic [DW-1:0]    diff;
    logic [WIDTH-1:0] r;
    logic             unused_diff_low;

    assign en     = !out_valid_reg || out_ready_i;
    assign accept = in_valid_i && en;
    assign xfer   = out_valid_reg && out_ready_i;

    // Only the low DW bits of each product are kept, so the same multiply
    // serves signed operands once they are sign-extended to DW.
    always_comb begin
        in_ext       = {{WIDTH{in_data_i[WIDTH-1]}}, in_data_i};
        s1_prod_next = in_ext * F_EXT;
    end

    assign s2_t_next = s1_prod_reg[WIDTH-1:0] * QINV_W;

    // t is chosen so the low half of p - t*Q is zero; the high half is the reduced value.
    always_comb begin
        t_ext         = {{WIDTH{s2_t_reg[WIDTH-1]}}, s2_t_reg};
        tq            = t_ext * Q_EXT;
        diff          = s2_prod_reg - tq;
        r             = diff[DW-1:WIDTH];
        out_data_next = r[WIDTH-1] ? (r + Q_W) : r;
    end

    assign unused_diff_low = |diff[WIDTH-1:0];

    always_comb begin
        in_cnt_next    = in_cnt_reg;
        out_cnt_next   = out_cnt_reg;
        frame_err_next = frame_err_reg;
        if (accept) begin
            in_cnt_next = (in_cnt_reg == LAST_IDX) ? '0 : in_cnt_reg + IW'(1);
            if (in_last_i != (in_cnt_reg == LAST_IDX)) begin
                frame_err_next = 1'b1;
            end
        end
        if (xfer) begin
            out_cnt_next = (out_cnt_reg == LAST_IDX) ? '0 : out_cnt_reg + IW'(1);
        end
    end

    // All stages advance together; bubbles shift exactly like valid data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_reg  <= 1'b0;
            s1_prod_reg   <= '0;
            s2_valid_reg  <= 1'b0;
            s2_prod_reg   <= '0;
            s2_t_reg      <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
        end else if (en) begin
            s1_valid_reg  <= accept;
            s1_prod_reg   <= s1_prod_next;
            s2_valid_reg  <= s1_valid_reg;
            s2_prod_reg   <= s1_prod_reg;
            s2_t_reg      <= s2_t_next;
            out_valid_reg <= s2_valid_reg;
            out_data_reg  <= out_data_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            in_cnt_reg    <= '0;
            out_cnt_reg   <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            in_cnt_reg    <= in_cnt_next;
            out_cnt_reg   <= out_cnt_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign in_ready_o  = en;
    assign out_valid_o = out_valid_reg;
    assign out_data_o  = out_data_reg;
    assign out_idx_o   = out_cnt_reg;
    assign out_last_o  = out_valid_reg && (out_cnt_reg == LAST_IDX);
    assign frame_err_o = frame_err_reg;

endmodule

// File: tb/tb_dili_intt_scale.sv
// Directed bench for dili_intt_scale: latency, canonical range, framing,
// backpressure stability, framing error and reset mid-stream.
`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_dili_intt_scale;

    localparam int Q = 8380417;
    localparam int N = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [7:0]  out_idx;
    logic        out_last;
    logic        frame_err;

    int n_cmp = 0;
    int n_fail = 0;
    int stalls = 0;
    int rdy_mode = 0;
    int exp_cnt = 0;

    logic [31:0] exp_data_q[$];
    logic [7:0]  exp_idx_q[$];
    logic        exp_last_q[$];
    logic [31:0] got_data_q[$];
    logic [7:0]  got_idx_q[$];
    logic        got_last_q[$];

    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic [7:0]  prev_idx = '0;
    logic        prev_last = 1'b0;

    dili_intt_scale dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_idx_o   (out_idx),
        .out_last_o  (out_last),
        .frame_err_o (frame_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // a * F * 2^-32 == a * 2^24 (mod Q); 2^24 mod Q = 16382.
    function automatic logic [31:0] ref_scale(input logic [31:0] a);
        longint m;
        m = longint'($signed(a)) % longint'(Q);
        if (m < 0) m = m + longint'(Q);
        return 32'((m * 64'sd16382) % longint'(Q));
    endfunction

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                `CHK("stall_valid", out_valid, 1'b1);
                `CHK("stall_data", out_data, prev_data);
                `CHK("stall_idx", out_idx, prev_idx);
                `CHK("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                got_data_q.push_back(out_data);
                got_idx_q.push_back(out_idx);
                got_last_q.push_back(out_last);
            end
            prev_stall <= out_valid && !out_ready;
            prev_data  <= out_data;
            prev_idx   <= out_idx;
            prev_last  <= out_last;
        end
    end

    task automatic send(input logic [31:0] d, input logic last, input logic [31:0] exp_val);
        bit acc;
        int tries;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc      = 1'b0;
        tries    = 0;
        while (!acc && tries < 1000) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) stalls++;
            tries++;
        end
        if (!acc) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_timeout: observed no accept, required accept within 1000 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        exp_data_q.push_back(exp_val);
        exp_idx_q.push_back(8'(exp_cnt));
        exp_last_q.push_back(exp_cnt == N - 1);
        exp_cnt = (exp_cnt + 1) % N;
    endtask

    task automatic clear_queues();
        exp_data_q.delete();
        exp_idx_q.delete();
        exp_last_q.delete();
        got_data_q.delete();
        got_idx_q.delete();
        got_last_q.delete();
    endtask

    task automatic drain_and_check(input string tag);
        int w;
        w = 0;
        rdy_mode = 0;
        while (got_data_q.size() < exp_data_q.size() && w < 300) begin
            @(posedge clk);
            w++;
        end
        repeat (6) @(posedge clk);
        #1;
        `CHK($sformatf("%s_count", tag), got_data_q.size(), exp_data_q.size());
        for (int i = 0; i < exp_data_q.size() && i < got_data_q.size(); i++) begin
            `CHK($sformatf("%s_data[%0d]", tag, i), got_data_q[i], exp_data_q[i]);
            `CHK($sformatf("%s_idx[%0d]", tag, i), got_idx_q[i], exp_idx_q[i]);
            `CHK($sformatf("%s_last[%0d]", tag, i), got_last_q[i], exp_last_q[i]);
            `CHK($sformatf("%s_range[%0d]", tag, i), (got_data_q[i] < 32'(Q)), 1'b1);
        end
        clear_queues();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        clear_queues();
        exp_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        `CHK("rst_out_valid", out_valid, 1'b0);
        `CHK("rst_out_data", out_data, 32'd0);
        `CHK("rst_out_idx", out_idx, 8'd0);
        `CHK("rst_out_last", out_last, 1'b0);
        `CHK("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: accept 256, output appears in the third cycle after acceptance
        in_valid = 1'b1;
        in_data  = 32'd256;
        in_last  = 1'b0;
        @(negedge clk);
        `CHK("t1_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        exp_data_q.push_back(32'd4193792);
        exp_idx_q.push_back(8'd0);
        exp_last_q.push_back(1'b0);
        exp_cnt = 1;
        @(negedge clk);
        `CHK("t1_valid_c1", out_valid, 1'b0);
        @(negedge clk);
        `CHK("t1_valid_c2", out_valid, 1'b0);
        @(negedge clk);
        `CHK("t1_valid_c3", out_valid, 1'b1);
        `CHK("t1_data_c3", out_data, 32'd4193792);
        `CHK("t1_idx_c3", out_idx, 8'd0);
        drain_and_check("t1");

        // T2: signs, multiples of Q and extreme inputs
        send(32'd0, 1'b0, 32'd0);
        send(32'hFFFF_FF00, 1'b0, 32'd4186625);
        send(32'd8380417, 1'b0, 32'd0);
        send(32'd1, 1'b0, 32'd16382);
        send(32'h7FFF_FFFF, 1'b0, ref_scale(32'h7FFF_FFFF));
        send(32'h8000_0000, 1'b0, ref_scale(32'h8000_0000));
        send(32'hFF80_1FFF, 1'b0, 32'd0);
        drain_and_check("t2");

        // T3: two aligned frames back to back at full rate
        do_reset();
        stalls = 0;
        for (int i = 0; i < 512; i++) begin
            logic [31:0] d;
            d = 32'(i * 40009 - 10000000);
            send(d, (i % 256) == 255, ref_scale(d));
        end
        `CHK("t3_no_stalls", stalls, 0);
        drain_and_check("t3");
        `CHK("t3_frame_err", frame_err, 1'b0);

        // T4: random backpressure over one frame
        rdy_mode = 1;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] d;
            d = $urandom;
            send(d, i == 255, ref_scale(d));
        end
        drain_and_check("t4");
        `CHK("t4_frame_err", frame_err, 1'b0);

        // T5: premature last on input 100 sets a sticky error
        for (int i = 0; i < 100; i++) begin
            send(32'(i * 777), 1'b0, ref_scale(32'(i * 777)));
        end
        `CHK("t5_err_before", frame_err, 1'b0);
        send(32'd77700, 1'b1, ref_scale(32'd77700));
        `CHK("t5_err_set", frame_err, 1'b1);
        for (int i = 0; i < 5; i++) begin
            send(32'(i + 5), 1'b0, ref_scale(32'(i + 5)));
        end
        drain_and_check("t5");
        repeat (10) @(posedge clk);
        #1;
        `CHK("t5_err_held", frame_err, 1'b1);

        // T6: reset with the first result on the output and two still in flight
        send(32'd11, 1'b0, ref_scale(32'd11));
        send(32'd22, 1'b0, ref_scale(32'd22));
        send(32'd33, 1'b0, ref_scale(32'd33));
        rst_n = 1'b0;
        #1;
        `CHK("t6_rst_valid", out_valid, 1'b0);
        `CHK("t6_rst_data", out_data, 32'd0);
        `CHK("t6_rst_idx", out_idx, 8'd0);
        `CHK("t6_rst_err", frame_err, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        clear_queues();
        exp_cnt = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(32'd777, 1'b0, ref_scale(32'd777));
        drain_and_check("t6");
        `CHK("t6_frame_err", frame_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
